// File: rtl/vgm_apb_master_bridge.sv
// Valid/ready request port to APB master bridge with a single outstanding transfer.
// Includes a response holding register and a PREADY timeout watchdog.
module vgm_apb_master_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic        PREADY,
  input  logic [31:0] PRDATA
);

  localparam int unsigned DW = 32;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam bit                   WDOG_EN  = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [DW-1:0]        paddr_q, paddr_d;
  logic [DW-1:0]        pwdata_q, pwdata_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]        rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_timeout_q, rsp_timeout_d;

  logic accept;
  logic wdog_hit;

  // Accept only when idle and any held response is gone or leaving this edge.
  assign req_ready = (state_q == IDLE) && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign wdog_hit  = WDOG_EN && !PREADY && (cnt_q == CNT_LAST);

  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (PREADY || wdog_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;

    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = req_write;
          paddr_d   = req_addr;
          pwdata_d  = req_wdata;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        // PREADY wins over a watchdog expiry on the same edge.
        if (PREADY) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
        end else if (wdog_hit) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: doc/vgm_apb_master_bridge.md
Name: vgm_apb_master_bridge

Overview:
- Single-outstanding request/response front end that converts a valid/ready transaction port into APB master signalling (PSEL/PENABLE/PADDR/PWRITE/PWDATA, PREADY/PRDATA).
- Sits directly upstream of the APB master interface and drives its signals.
- Adds a response holding register and a PREADY timeout watchdog, so the bus is released even if a slave never answers.

Parameters:
- TIMEOUT_CYCLES, 16, number of consecutive ACCESS cycles with PREADY=0 before abort; 0 disables the watchdog.
- CNT_WIDTH, 8, width of the wait counter; TIMEOUT_CYCLES must be <= 2**CNT_WIDTH-1.

Ports:
- PCLK  input  1  clock; all logic on posedge.
- PRESET  input  1  reset.
- req_valid  input  1  request present.
- req_ready  output  1  bridge accepts request this cycle.
- req_addr  input  32  transfer address.
- req_write  input  1  1=write, 0=read.
- req_wdata  input  32  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_rdata  output  32  read data; 0 for writes and timeouts.
- rsp_timeout  output  1  transfer aborted by watchdog.
- PSEL, PENABLE, PWRITE  output  1 each  APB controls.
- PADDR, PWDATA  output  32 each  APB address and write data.
- PREADY  input  1  slave ready.
- PRDATA  input  32  slave read data.

Behaviour:
- One clock, PCLK. Reset PRESET is synchronous and active-high.
- Reset values: state=IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_timeout and the wait counter are all 0. req_ready is combinational and therefore 1 after reset.
- States: IDLE, SETUP, ACCESS.
- req_ready = (state==IDLE) && (!rsp_valid || rsp_ready), purely combinational. A new request may be accepted in the same cycle the previous response drains.
- Accept = req_valid && req_ready at posedge. On accept:
  - PADDR, PWRITE, PWDATA are registered from req_*.
  - PSEL=1, PENABLE=0, state goes to SETUP.
- SETUP -> ACCESS unconditionally next edge: PENABLE=1 and the wait counter is cleared.
- In ACCESS:
  - PSEL, PENABLE, PADDR, PWRITE and PWDATA are held stable.
  - Completion occurs at an edge where PREADY=1.
  - Otherwise the counter increments, saturating at 2**CNT_WIDTH-1.
- Completion, at the same edge:
  - PSEL=0, PENABLE=0, state goes to IDLE.
  - rsp_valid=1 and rsp_timeout=0.
  - rsp_rdata = PRDATA for a read, 0 for a write.
- Timeout (TIMEOUT_CYCLES>0): at the edge where PREADY=0 and counter == TIMEOUT_CYCLES-1:
  - Same as completion, except rsp_timeout=1 and rsp_rdata=0.
  - PREADY=1 on that same edge takes priority: the transfer completes normally.
- Latency:
  - Accept at edge E: SETUP in cycle E+1, ACCESS from E+2.
  - Zero-wait slave gives rsp_valid from E+3.
  - Minimum spacing between accepts is 3 cycles.
- Response register:
  - rsp_valid, rsp_rdata and rsp_timeout are held until the edge where rsp_valid && rsp_ready; rsp_valid then clears unless a new response is loaded on the same edge.
  - A load cannot coincide with an undrained response, because accept is gated by the drain.
- Idle bus: PADDR, PWRITE and PWDATA keep their last values (no toggling); PENABLE is never 1 while PSEL is 0.
- Reset mid-transfer (PRESET in SETUP or ACCESS, or while rsp_valid is pending): all reset values apply at that edge. The in-flight transfer and pending response are discarded with no response issued.
- Inputs req_* are ignored whenever req_ready=0.

Test Plan:
- Read, zero-wait: req_addr=0x100, PREADY tied 1, PRDATA=0xDEADBEEF.
  -> PSEL rises cycle+1, PENABLE cycle+2; rsp_valid=1 at cycle+3 with rsp_rdata=0xDEADBEEF, rsp_timeout=0.
- Write, 3 wait states: req_write=1, req_wdata=0x12345678, PREADY low 3 ACCESS cycles.
  -> PADDR/PWDATA stable for all 4 ACCESS cycles; response rdata=0, timeout=0.
- Timeout: TIMEOUT_CYCLES=4, PREADY held 0.
  -> exactly 4 ACCESS cycles, then PSEL=PENABLE=0 and rsp_valid=1, rsp_timeout=1, rsp_rdata=0.
  -> Variant with PREADY=1 on the 4th ACCESS cycle completes normally.
- Backpressure: rsp_ready=0 for 10 cycles with req_valid held 1.
  -> req_ready stays 0 and no second SETUP occurs.
  -> When rsp_ready=1, the second transfer is accepted on the same edge the first response drains.
- Back-to-back: 3 reads with rsp_ready=1 and zero-wait slave.
  -> accepts exactly 3 cycles apart, responses in order with matching rdata.
- Reset mid-ACCESS: assert PRESET for 1 cycle during a waited read.
  -> next edge PSEL=PENABLE=rsp_valid=0, state IDLE, no response for the aborted read, req_ready=1.
